// File: rtl/instrumented_adder_ripple_wrapper.sv
// -----------------------------------------------------------------------------
// instrumented_adder_ripple_wrapper
//
// A 32-bit ripple-carry adder with a ring-oscillation harness that
// characterises the carry path. Operands and masks are loaded over the LA
// buses. In ring mode a selected sum bit is inverted and fed back into
// chosen bits of the A operand once per clock. Each change of that feedback
// bit increments a toggle counter.
//
// Ports
//   wb_clk_i        : single clock; all state changes on its rising edge
//   wb_rst_i        : synchronous, active-high reset (highest priority)
//   active          : project select; 0 freezes all state and parks outputs
//   la1_data_in     : A operand / ext_mask / ring_mask / sel data
//   la2_data_in     : B operand data
//   la3_data_in     : [2:0] command, [3] ring_en, [31:4] ignored
//   la1/2/3_oenb    : unused
//   io_in           : unused
//   la1_data_out    : registered sum[31:0]
//   la2_data_out    : {31'b0, registered carry-out}
//   la3_data_out    : toggle counter
//   io_out          : [0] ring_fb, [1] carry-out, [37:2] zero
//   io_oeb          : [1:0] driven (0), [37:2] released (1)
//
// Handshake: there is none. Every command is a single-cycle strobe that is
// acted on at the rising edge on which it is sampled while active = 1.
// -----------------------------------------------------------------------------
module instrumented_adder_ripple_wrapper (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        active,
  input  logic [31:0] la1_data_in,
  input  logic [31:0] la2_data_in,
  input  logic [31:0] la3_data_in,
  input  logic [31:0] la1_oenb,
  input  logic [31:0] la2_oenb,
  input  logic [31:0] la3_oenb,
  input  logic [37:0] io_in,
  output logic [31:0] la1_data_out,
  output logic [31:0] la2_data_out,
  output logic [31:0] la3_data_out,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  typedef enum logic [2:0] {
    CMD_NOP0     = 3'd0,
    CMD_LOAD_A   = 3'd1,
    CMD_LOAD_B   = 3'd2,
    CMD_LOAD_EXT = 3'd3,
    CMD_LOAD_RNG = 3'd4,
    CMD_LOAD_SEL = 3'd5,
    CMD_CLR_CNT  = 3'd6,
    CMD_NOP7     = 3'd7
  } cmd_e;

  cmd_e        cmd;
  logic        ring_en;

  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] ext_mask;
  logic [31:0] ring_mask;
  logic [4:0]  sel;
  logic        ring_fb;
  logic [31:0] count;
  logic [31:0] sum_q;
  logic        cout_q;

  logic [31:0] a_eff;
  logic [31:0] sum;
  logic        cout;
  logic        next_fb;
  logic        toggle;

  // Inputs that exist only to fill out the user-area pinout.
  logic        unused_inputs;
  assign unused_inputs = ^{la1_oenb, la2_oenb, la3_oenb, io_in, la3_data_in[31:4]};

  assign cmd     = cmd_e'(la3_data_in[2:0]);
  assign ring_en = la3_data_in[3];

  // Ring bits override external bits; bits in neither mask read as 0.
  assign a_eff = (ring_mask & {32{ring_fb}}) | (~ring_mask & ext_mask & a_reg);

  // Explicit bit-serial ripple so the carry chain is a real chain of
  // full adders, which is what the ring mode is there to exercise.
  always_comb begin : ripple
    logic c;
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a_eff[i] ^ b_reg[i] ^ c;
      c      = (a_eff[i] & b_reg[i]) | (c & (a_eff[i] ^ b_reg[i]));
    end
    cout = c;
  end

  // Feedback is derived from the sum of the current (pre-edge) ring_fb.
  assign next_fb = ~sum[sel];
  assign toggle  = ring_en && (next_fb != ring_fb);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_reg     <= '0;
      b_reg     <= '0;
      ext_mask  <= 32'hFFFF_FFFF;
      ring_mask <= '0;
      sel       <= '0;
      ring_fb   <= 1'b0;
      count     <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else if (active) begin
      sum_q  <= sum;
      cout_q <= cout;

      case (cmd)
        CMD_LOAD_A:   a_reg     <= la1_data_in;
        CMD_LOAD_B:   b_reg     <= la2_data_in;
        CMD_LOAD_EXT: ext_mask  <= la1_data_in;
        CMD_LOAD_RNG: ring_mask <= la1_data_in;
        CMD_LOAD_SEL: sel       <= la1_data_in[4:0];
        default: ;
      endcase

      if (ring_en) begin
        ring_fb <= next_fb;
      end

      // A clear in the same cycle as a toggle leaves the counter at zero.
      if (cmd == CMD_CLR_CNT) begin
        count <= '0;
      end else if (toggle) begin
        count <= count + 32'd1;
      end
    end
  end

  // Outputs are parked whenever the project is deselected.
  always_comb begin
    la1_data_out = '0;
    la2_data_out = '0;
    la3_data_out = '0;
    io_out       = '0;
    io_oeb       = {38{1'b1}};
    if (active) begin
      la1_data_out = sum_q;
      la2_data_out = {31'b0, cout_q};
      la3_data_out = count;
      io_out       = {36'b0, cout_q, ring_fb};
      io_oeb       = {36'hF_FFFF_FFFF, 2'b00};
    end
  end

endmodule

// File: tb/tb_instrumented_adder_ripple_wrapper.sv
// -----------------------------------------------------------------------------
// Bench for instrumented_adder_ripple_wrapper: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that treats
// the adder as plain 33-bit arithmetic.
// -----------------------------------------------------------------------------
module tb_instrumented_adder_ripple_wrapper;

  // ---------------- clock / reset ----------------
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        active   = 1'b0;
  logic [31:0] la1_data_in = '0;
  logic [31:0] la2_data_in = '0;
  logic [31:0] la3_data_in = '0;
  logic [31:0] la1_oenb = '1;
  logic [31:0] la2_oenb = '1;
  logic [31:0] la3_oenb = '1;
  logic [37:0] io_in = '0;
  logic [31:0] la1_data_out;
  logic [31:0] la2_data_out;
  logic [31:0] la3_data_out;
  logic [37:0] io_out;
  logic [37:0] io_oeb;

  always #5 wb_clk_i = ~wb_clk_i;

  instrumented_adder_ripple_wrapper dut (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .active       (active),
    .la1_data_in  (la1_data_in),
    .la2_data_in  (la2_data_in),
    .la3_data_in  (la3_data_in),
    .la1_oenb     (la1_oenb),
    .la2_oenb     (la2_oenb),
    .la3_oenb     (la3_oenb),
    .io_in        (io_in),
    .la1_data_out (la1_data_out),
    .la2_data_out (la2_data_out),
    .la3_data_out (la3_data_out),
    .io_out       (io_out),
    .io_oeb       (io_oeb)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_a, m_b, m_ext, m_ring, m_cnt, m_sum;
  logic [4:0]  m_sel;
  logic        m_fb, m_cout;

  task automatic model_edge(input logic rst, input logic act, input logic [2:0] cmd,
                            input logic ren, input logic [31:0] d1, input logic [31:0] d2);
    logic [31:0] aeff;
    logic [32:0] total;
    logic        nfb;
    if (rst) begin
      m_a = 0; m_b = 0; m_ext = 32'hFFFF_FFFF; m_ring = 0; m_sel = 0;
      m_fb = 0; m_cnt = 0; m_sum = 0; m_cout = 0;
    end else if (act) begin
      aeff = 0;
      for (int i = 0; i < 32; i++)
        aeff[i] = m_ring[i] ? m_fb : (m_ext[i] ? m_a[i] : 1'b0);
      total = {1'b0, aeff} + {1'b0, m_b};
      nfb   = ~total[m_sel];
      m_sum  = total[31:0];
      m_cout = total[32];
      if (ren) begin
        if (nfb != m_fb) m_cnt = m_cnt + 1;
        m_fb = nfb;
      end
      case (cmd)
        3'd1: m_a    = d1;
        3'd2: m_b    = d2;
        3'd3: m_ext  = d1;
        3'd4: m_ring = d1;
        3'd5: m_sel  = d1[4:0];
        3'd6: m_cnt  = 0;
        default: ;
      endcase
    end
    exp_q.push_back(act ? m_sum : 32'h0);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic act, input logic [2:0] cmd,
                       input logic ren, input logic [31:0] d1, input logic [31:0] d2);
    wb_rst_i    = rst;
    active      = act;
    la1_data_in = d1;
    la2_data_in = d2;
    la3_data_in = {28'($urandom), ren, cmd};
    la1_oenb    = $urandom;
    io_in       = {6'($urandom), 32'($urandom)};
    @(posedge wb_clk_i);
    model_edge(rst, act, cmd, ren, d1, d2);
    #1;
    check("la1_sum", {32'b0, la1_data_out}, {32'b0, exp_q.pop_front()});
    check("la2_cout", {32'b0, la2_data_out}, act ? {63'b0, m_cout} : 64'h0);
    check("la3_count", {32'b0, la3_data_out}, act ? {32'b0, m_cnt} : 64'h0);
    check("io_out", {26'b0, io_out}, act ? {62'b0, m_cout, m_fb} : 64'h0);
    check("io_oeb", {26'b0, io_oeb}, act ? {26'b0, 36'hF_FFFF_FFFF, 2'b00} : {26'b0, {38{1'b1}}});
  endtask

  task automatic cmd_cycle(input logic [2:0] cmd, input logic [31:0] d);
    cycle(1'b0, 1'b1, cmd, 1'b0, d, d);
  endtask

  task automatic reset_cycle();
    cycle(1'b1, 1'b1, 3'd0, 1'b1, 32'h0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_cycle();
    reset_cycle();
    check("rst_count", {32'b0, la3_data_out}, 64'h0);
    check("rst_io_out", {26'b0, io_out}, 64'h0);

    // Overflow: FFFF_FFFF + 1 wraps to 0 with carry out.
    cmd_cycle(3'd1, 32'hFFFF_FFFF);
    cmd_cycle(3'd2, 32'h0000_0001);
    cmd_cycle(3'd0, 32'h0);
    cmd_cycle(3'd0, 32'h0);
    check("ovf_sum", {32'b0, la1_data_out}, 64'h0);
    check("ovf_cout", {32'b0, la2_data_out}, 64'h1);
    check("ovf_io1", {63'b0, io_out[1]}, 64'h1);

    // Plain add, then mask out A entirely.
    cmd_cycle(3'd1, 32'h1234_5678);
    cmd_cycle(3'd2, 32'h1111_1111);
    cmd_cycle(3'd0, 32'h0);
    check("add_sum", {32'b0, la1_data_out}, 64'h2345_6789);
    check("add_cout", {32'b0, la2_data_out}, 64'h0);
    cmd_cycle(3'd3, 32'h0);
    cmd_cycle(3'd0, 32'h0);
    check("ext0_sum", {32'b0, la1_data_out}, 64'h1111_1111);

    // Ring on bit 0 with a = b = 0: toggles every cycle.
    cmd_cycle(3'd1, 32'h0);
    cmd_cycle(3'd2, 32'h0);
    cmd_cycle(3'd3, 32'hFFFF_FFFF);
    cmd_cycle(3'd4, 32'h1);
    cmd_cycle(3'd5, 32'h0);
    cmd_cycle(3'd6, 32'h0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 3'd0, 1'b1, 32'h0, 32'h0);
    check("ring10_count", {32'b0, la3_data_out}, 64'd10);
    cycle(1'b0, 1'b1, 3'd6, 1'b1, 32'h0, 32'h0);
    check("clr_vs_toggle", {32'b0, la3_data_out}, 64'h0);

    // b = 1 makes sum[0] = ~ring_fb: the loop is stable at 0.
    reset_cycle();
    cmd_cycle(3'd4, 32'h1);
    cmd_cycle(3'd2, 32'h1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 3'd0, 1'b1, 32'h0, 32'h0);
    check("stable_fb", {63'b0, io_out[0]}, 64'h0);
    check("stable_count", {32'b0, la3_data_out}, 64'h0);

    // Full carry chain: 0x7FFF_FFFE + fb + 1 flips sum[31] each cycle.
    reset_cycle();
    cmd_cycle(3'd4, 32'h1);
    cmd_cycle(3'd1, 32'h7FFF_FFFE);
    cmd_cycle(3'd2, 32'h1);
    cmd_cycle(3'd5, 32'd31);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 3'd0, 1'b1, 32'h0, 32'h0);
    check("carry_count", {32'b0, la3_data_out}, 64'd8);

    // Deselect mid-ring, then resume from the held count.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 3'd6, 1'b1, 32'h0, 32'h0);
    check("park_oeb", {26'b0, io_oeb}, {26'b0, {38{1'b1}}});
    cycle(1'b0, 1'b1, 3'd0, 1'b0, 32'h0, 32'h0);
    check("held_count", {32'b0, la3_data_out}, 64'd8);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 3'd0, 1'b1, 32'h0, 32'h0);
    check("resume_count", {32'b0, la3_data_out}, 64'd11);
    reset_cycle();
    check("midrun_rst_cnt", {32'b0, la3_data_out}, 64'h0);
    check("midrun_rst_fb", {63'b0, io_out[0]}, 64'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        rst, act, ren;
      logic [2:0]  cmd;
      logic [31:0] d1, d2;
      rst = ($urandom_range(0, 49) == 0);
      act = ($urandom_range(0, 9) != 0);
      ren = ($urandom_range(0, 2) != 0);
      cmd = 3'($urandom_range(0, 7));
      d1  = $urandom;
      d2  = $urandom;
      // Small masks and values keep the ring in interesting regions.
      if ($urandom_range(0, 1) == 1) d1 = d1 & 32'h0000_000F;
      if ($urandom_range(0, 1) == 1) d2 = d2 & 32'h0000_0003;
      cycle(rst, act, cmd, ren, d1, d2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
